xmac_pipe: RTL

//  Parametrised, pipelined, back-pressurable multiply / multiply-accumulate unit for reduced-radix

---
 rtl/xmac_pipe_if.sv | 29 ++
 rtl/xmac_pipe.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/xmac_pipe_if.sv
// Request/response bundle for the xmac_pipe multiply/MAC unit.
// The master issues requests and consumes results; the slave is the unit.
interface xmac_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [5:0]       req_fn;
    logic             req_dw;
    logic [TAG_W-1:0] req_tag;
    logic [XLEN-1:0]  req_in1;
    logic [XLEN-1:0]  req_in2;
    logic [XLEN-1:0]  req_in3;
    logic             resp_valid;
    logic             resp_ready;
    logic [XLEN-1:0]  resp_data;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output req_valid, req_fn, req_dw, req_tag, req_in1, req_in2, req_in3, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag
    );

    modport slave (
        input  req_valid, req_fn, req_dw, req_tag, req_in1, req_in2, req_in3, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag
    );
endinterface

// File: rtl/xmac_pipe.sv
// Pipelined, back-pressurable multiply / multiply-accumulate unit for
// reduced-radix limb arithmetic. Stage 1 captures the request, the product
// is carried through stages 1..STAGES-1, and the final (output) stage adds
// the accumulate operand and selects the result. A stalled output freezes
// the whole pipe, so bubbles are preserved and results stay in order.
module xmac_pipe #(
    parameter int XLEN   = 64,
    parameter int RADIX  = 51,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic clock,
    input  logic reset,
    xmac_pipe_if.slave bus
);
    localparam int PW   = 2 * XLEN;
    localparam int LAST = STAGES - 1;

    localparam logic [5:0] FN_MUL    = 6'd0;
    localparam logic [5:0] FN_MULH   = 6'd1;
    localparam logic [5:0] FN_MULHSU = 6'd2;
    localparam logic [5:0] FN_MULHU  = 6'd3;
    localparam logic [5:0] FN_MADDL  = 6'd50;
    localparam logic [5:0] FN_MADDH  = 6'd51;
    localparam logic [5:0] FN_CADD   = 6'd52;

    // Low RADIX bits of the product feed MADDL.
    localparam logic [XLEN-1:0] LO_MASK = {XLEN{1'b1}} >> (XLEN - RADIX);

    // Final-stage result select; unsupported codes yield zero.
    function automatic logic [XLEN-1:0] calc_result(
        input logic [5:0]      fn,
        input logic            dw,
        input logic [PW-1:0]   prod,
        input logic [XLEN-1:0] in1,
        input logic [XLEN-1:0] in2,
        input logic [XLEN-1:0] in3
    );
        case (fn)
            FN_MUL: begin
                if (!dw && XLEN == 64) return XLEN'($signed(prod[31:0]));
                else                   return prod[XLEN-1:0];
            end
            FN_MULH, FN_MULHSU, FN_MULHU: return prod[XLEN +: XLEN];
            FN_MADDL: return (prod[XLEN-1:0] & LO_MASK) + in3;
            FN_MADDH: return prod[RADIX +: XLEN] + in3;
            FN_CADD:  return (in1 >> RADIX) + in2;
            default:  return '0;
        endcase
    endfunction

    logic stall;
    logic adv;
    logic accept;

    logic             vld_p [1:LAST];
    logic [5:0]       fn_p  [1:LAST];
    logic             dw_p  [1:LAST];
    logic [TAG_W-1:0] tag_p [1:LAST];
    logic [XLEN-1:0]  in1_p [1:LAST];
    logic [XLEN-1:0]  in2_p [1:LAST];
    logic [XLEN-1:0]  in3_p [1:LAST];

    logic            lhs_sgn;
    logic            rhs_sgn;
    logic [PW-1:0]   lhs_x;
    logic [PW-1:0]   rhs_x;
    logic [PW-1:0]   prod_p1;
    logic [PW-1:0]   prod_fin;
    logic [XLEN-1:0] result_fin;

    logic             resp_valid_q;
    logic [XLEN-1:0]  resp_data_q;
    logic [TAG_W-1:0] resp_tag_q;

    assign stall          = resp_valid_q & ~bus.resp_ready;
    assign adv            = ~stall;
    assign accept         = bus.req_valid & adv;
    assign bus.req_ready  = adv;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_tag   = resp_tag_q;

    // Stage valids advance together whenever the output is not stalled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 1; k <= LAST; k++) vld_p[k] <= 1'b0;
        end else if (adv) begin
            vld_p[1] <= bus.req_valid;
            for (int k = 2; k <= LAST; k++) vld_p[k] <= vld_p[k-1];
        end
    end

    // Operand and tag pipeline; contents only matter where the matching valid is set.
    always_ff @(posedge clock) begin
        if (accept) begin
            fn_p[1]  <= bus.req_fn;
            dw_p[1]  <= bus.req_dw;
            tag_p[1] <= bus.req_tag;
            in1_p[1] <= bus.req_in1;
            in2_p[1] <= bus.req_in2;
            in3_p[1] <= bus.req_in3;
        end
        if (adv) begin
            for (int k = 2; k <= LAST; k++) begin
                fn_p[k]  <= fn_p[k-1];
                dw_p[k]  <= dw_p[k-1];
                tag_p[k] <= tag_p[k-1];
                in1_p[k] <= in1_p[k-1];
                in2_p[k] <= in2_p[k-1];
                in3_p[k] <= in3_p[k-1];
            end
        end
    end

    // Operands are sign- or zero-extended to the full product width, so the
    // truncated unsigned product equals the low 2*XLEN bits of the true product.
    always_comb begin
        lhs_sgn = (fn_p[1] == FN_MULH) || (fn_p[1] == FN_MULHSU);
        rhs_sgn = (fn_p[1] == FN_MULH);
        lhs_x   = {{XLEN{lhs_sgn & in1_p[1][XLEN-1]}}, in1_p[1]};
        rhs_x   = {{XLEN{rhs_sgn & in2_p[1][XLEN-1]}}, in2_p[1]};
        prod_p1 = lhs_x * rhs_x;
    end

    generate
        if (STAGES == 2) begin : g_prod_direct
            assign prod_fin = prod_p1;
        end else begin : g_prod_deep
            logic [PW-1:0] prod_d [2:LAST];

            // ---- product stages 2..STAGES-1 (retimable into the multiplier) ----
            always_ff @(posedge clock) begin
                if (adv) begin
                    prod_d[2] <= prod_p1;
                    for (int k = 3; k <= LAST; k++) prod_d[k] <= prod_d[k-1];
                end
            end

            assign prod_fin = prod_d[LAST];
        end
    endgenerate

    assign result_fin = calc_result(fn_p[LAST], dw_p[LAST], prod_fin,
                                    in1_p[LAST], in2_p[LAST], in3_p[LAST]);

    // ---- output stage: accumulate, select and hold the response ----
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
        end else if (adv) begin
            resp_valid_q <= vld_p[LAST];
            if (vld_p[LAST]) begin
                resp_data_q <= result_fin;
                resp_tag_q  <= tag_p[LAST];
            end
        end
    end
endmodule
